qdiv: RTL and testbench

QDIV -- requirements
Module: qdiv

---
 rtl/qdiv.sv | 120 ++++++++++++
 tb/tb_qdiv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/qdiv.sv
// Sign-magnitude Q-format divider: restoring shift-subtract, one quotient bit per clock,
// with saturation on overflow and a single-edge shortcut for a zero divisor.
module qdiv #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         dbz
);

  localparam int W  = N - 1 + Q;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [W-1:0]  work;
  logic [W-1:0]  work_next;
  logic [N-1:0]  rem;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  rem_shift;
  logic [N-1:0]  rem_diff;
  logic [N-2:0]  divisor;
  logic [CW-1:0] cnt;
  logic          sign;
  logic          q_bit;
  logic          accept;
  logic          div_zero;
  logic          last;
  logic          ovf_final;
  logic [N-2:0]  mag_final;

  assign accept   = start && (state != CALC);
  assign div_zero = (b[N-2:0] == '0);
  assign last     = (state == CALC) && (cnt == '0);
  assign busy     = (state == CALC);
  assign done     = (state == DONE);

  // One restoring step; on the final step the saturated magnitude is taken straight from it
  always_comb begin
    rem_shift = {rem[N-2:0], work[W-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_next  = q_bit ? rem_diff : rem_shift;
    work_next = {work[W-2:0], q_bit};
    ovf_final = |work_next[W-1:N-1];
    mag_final = ovf_final ? {(N-1){1'b1}} : work_next[N-2:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = div_zero ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        if (start) state_next = div_zero ? DONE : CALC;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The counter reloads on every accept, so an aborted or previous run leaves nothing behind
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      q       <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
    end else if (accept) begin
      sign    <= a[N-1] ^ b[N-1];
      divisor <= b[N-2:0];
      work    <= {a[N-2:0], {Q{1'b0}}};
      rem     <= '0;
      cnt     <= CW'(W - 1);
      if (div_zero) begin
        q   <= {a[N-1], {(N-1){1'b1}}};
        ovf <= 1'b1;
        dbz <= 1'b1;
      end
    end else if (state == CALC) begin
      work <= work_next;
      rem  <= rem_next;
      if (last) begin
        q   <= {sign & (|mag_final), mag_final};
        ovf <= ovf_final;
        dbz <= 1'b0;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_qdiv.sv
// Directed bench for qdiv (Q=15, N=32): hand-computed quotients, latency, saturation,
// divide-by-zero, back-to-back operation and reset abort.
module tb_qdiv;

  localparam int Q = 15;
  localparam int N = 32;
  localparam int LAT = N + Q - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q;
  logic         busy;
  logic         done;
  logic         ovf;
  logic         dbz;

  int compared   = 0;
  int mismatched = 0;
  int edges;
  int busy_cycles;
  int total;
  int done_pulses;

  always #5 clk = ~clk;

  qdiv #(.Q(Q), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .dbz  (dbz)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Leaves the bench at the falling edge right after the accepting edge
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitDone(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    while (!done && n_edges < 200) begin
      if (busy) n_busy++;
      step();
      n_edges++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_q", 64'(q), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_done", 64'(done), 64'h0);
    checkOutput("rst_ovf", 64'(ovf), 64'h0);
    checkOutput("rst_dbz", 64'(dbz), 64'h0);
    rst = 1'b0;
    step();

    // 3.0 / 1.5 = 2.0
    applyStimulus(32'h0001_8000, 32'h0000_C000);
    waitDone(edges, busy_cycles);
    checkOutput("lat_3_15", 64'(edges), 64'(LAT));
    checkOutput("busy_3_15", 64'(busy_cycles), 64'(LAT));
    checkOutput("q_3_15", 64'(q), 64'h0001_0000);
    checkOutput("ovf_3_15", 64'(ovf), 64'h0);
    checkOutput("dbz_3_15", 64'(dbz), 64'h0);
    step();
    checkOutput("done_one_cycle", 64'(done), 64'h0);
    checkOutput("idle_busy", 64'(busy), 64'h0);
    checkOutput("q_hold", 64'(q), 64'h0001_0000);

    // -1.0 / 4.0 = -0.25
    applyStimulus(32'h8000_8000, 32'h0002_0000);
    waitDone(edges, busy_cycles);
    checkOutput("q_neg", 64'(q), 64'h8000_2000);
    checkOutput("ovf_neg", 64'(ovf), 64'h0);
    step();

    // tiny / -4.0 truncates to zero, which must not carry the sign
    applyStimulus(32'h0000_0001, 32'h8002_0000);
    waitDone(edges, busy_cycles);
    checkOutput("q_negzero", 64'(q), 64'h0000_0000);
    step();

    // divide by negative zero
    applyStimulus(32'h8001_8000, 32'h8000_0000);
    checkOutput("dbz_done_now", 64'(done), 64'h1);
    checkOutput("dbz_busy", 64'(busy), 64'h0);
    checkOutput("dbz_q", 64'(q), 64'hFFFF_FFFF);
    checkOutput("dbz_flag", 64'(dbz), 64'h1);
    checkOutput("dbz_ovf", 64'(ovf), 64'h1);
    step();
    checkOutput("dbz_done_drop", 64'(done), 64'h0);

    // saturation
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001);
    waitDone(edges, busy_cycles);
    checkOutput("sat_q", 64'(q), 64'h7FFF_FFFF);
    checkOutput("sat_ovf", 64'(ovf), 64'h1);
    checkOutput("sat_dbz", 64'(dbz), 64'h0);
    step();

    applyStimulus(32'h0000_8000, 32'h0000_8000);
    waitDone(edges, busy_cycles);
    checkOutput("one_q", 64'(q), 64'h0000_8000);
    checkOutput("one_ovf", 64'(ovf), 64'h0);
    step();

    // operands and start disturbed mid-CALC
    applyStimulus(32'h0001_8000, 32'h0000_C000);
    checkOutput("accept_keeps_q", 64'(q), 64'h0000_8000);
    total = 0;
    repeat (10) begin
      step();
      total++;
    end
    a     = 32'h7FFF_FFFF;
    b     = 32'h0000_0001;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    waitDone(edges, busy_cycles);
    total += edges;
    checkOutput("mid_lat", 64'(total), 64'(LAT));
    checkOutput("mid_q", 64'(q), 64'h0001_0000);
    checkOutput("mid_ovf", 64'(ovf), 64'h0);
    step();

    // back-to-back with start held high
    a     = 32'h8000_8000;
    b     = 32'h0002_0000;
    start = 1'b1;
    step();
    waitDone(edges, busy_cycles);
    checkOutput("b2b_lat", 64'(edges), 64'(LAT));
    checkOutput("b2b_q1", 64'(q), 64'h8000_2000);
    step();
    repeat (5) step();
    a = 32'h0001_8000;
    b = 32'h0000_C000;
    waitDone(edges, busy_cycles);
    checkOutput("b2b_period", 64'(edges + 6), 64'(LAT + 1));
    checkOutput("b2b_q2", 64'(q), 64'h8000_2000);
    step();
    waitDone(edges, busy_cycles);
    checkOutput("b2b_period3", 64'(edges + 1), 64'(LAT + 1));
    checkOutput("b2b_q3", 64'(q), 64'h0001_0000);
    start = 1'b0;
    step();
    checkOutput("b2b_stop", 64'(done), 64'h0);

    // reset abort 20 cycles into CALC
    applyStimulus(32'h0001_8000, 32'h0000_C000);
    repeat (20) step();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_q", 64'(q), 64'h0);
    checkOutput("abort_busy", 64'(busy), 64'h0);
    checkOutput("abort_done", 64'(done), 64'h0);
    checkOutput("abort_ovf", 64'(ovf), 64'h0);
    checkOutput("abort_dbz", 64'(dbz), 64'h0);
    @(negedge clk);
    step();
    rst = 1'b0;
    done_pulses = 0;
    repeat (60) begin
      step();
      if (done) done_pulses++;
    end
    checkOutput("abort_no_done", 64'(done_pulses), 64'h0);
    applyStimulus(32'h8000_8000, 32'h0002_0000);
    waitDone(edges, busy_cycles);
    checkOutput("post_rst_lat", 64'(edges), 64'(LAT));
    checkOutput("post_rst_q", 64'(q), 64'h8000_2000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
